// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the load/store unit (port 0)
// and a DMA/debug master (port 1), with bounded lock bursts and registered responses.
//
// state | meaning
// IDLE  | no owner; contested cycles follow round-robin on last
// OWN0  | port 0 holds the lock; wins contested cycles while hold < MAX_HOLD
// OWN1  | port 1 holds the lock; wins contested cycles while hold < MAX_HOLD
module dmem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    owner_t     owner;
    logic       last;
    logic [3:0] hold;

    logic   g0, g1;
    logic   hold_ok;
    logic   g_lock, other_req;
    owner_t g_own;

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        hold_ok = (hold < HOLD_MAX);
        // Grants are suppressed during reset so nothing reaches the memory.
        if (!rst) begin
            if (r0_req && !r1_req) begin
                g0 = 1'b1;
            end else if (r1_req && !r0_req) begin
                g1 = 1'b1;
            end else if (r0_req && r1_req) begin
                if (owner == OWN0 && r0_lock && hold_ok)
                    g0 = 1'b1;
                else if (owner == OWN1 && r1_lock && hold_ok)
                    g1 = 1'b1;
                else if (last)
                    g0 = 1'b1;
                else
                    g1 = 1'b1;
            end
        end
    end

    always_comb begin
        g_lock    = g1 ? r1_lock : r0_lock;
        other_req = g1 ? r0_req  : r1_req;
        g_own     = g1 ? OWN1    : OWN0;
    end

    assign r0_gnt   = g0;
    assign r1_gnt   = g1;
    assign mem_addr = g1 ? r1_addr  : r0_addr;
    assign mem_din  = g1 ? r1_wdata : r0_wdata;
    assign mem_we   = (g0 & r0_we) | (g1 & r1_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= IDLE;
            last     <= 1'b1;
            hold     <= 4'd0;
            r0_ack   <= 1'b0;
            r1_ack   <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            r0_ack <= g0;
            r1_ack <= g1;
            if (g0 && !r0_we)
                r0_rdata <= mem_dout;
            if (g1 && !r1_we)
                r1_rdata <= mem_dout;

            if (g0 || g1) begin
                last <= g1;
                if (g_lock) begin
                    owner <= g_own;
                    // Only contested grants to the same owner count toward the limit.
                    if (owner == g_own && other_req)
                        hold <= (hold >= HOLD_MAX) ? HOLD_MAX : 4'(hold + 4'd1);
                    else
                        hold <= 4'd1;
                end else begin
                    owner <= IDLE;
                    hold  <= 4'd0;
                end
            end else begin
                owner <= IDLE;
                hold  <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural memory model, with hand-computed grant
// sequences and read data checked against constants.
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_req, r0_we, r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt, r0_ack;
    logic [DATA_W-1:0] r0_rdata;
    logic              r1_req, r1_we, r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt, r1_ack;
    logic [DATA_W-1:0] r1_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    // Each vector entry: expected r1_gnt (r0_gnt must be its complement) for one contested cycle.
    logic alt_exp   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic burst_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic relax_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        idle_all();
        rst = 1'b1;
        r0_req = 1; r0_we = 1; r0_addr = 5'd5; r0_wdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("rst_gnt0",   r0_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_ack0",   r0_ack, 0);
        chk("rst_rdata0", r0_rdata, 0);

        // Single write then read by port 0
        rst = 1'b0;
        #1;
        chk("wr_gnt0",   r0_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_addr",   mem_addr, 5);
        chk("wr_din",    mem_din, 16'hBEEF);
        @(negedge clk);
        chk("wr_ack0",   r0_ack, 1);
        chk("wr_rdata_held", r0_rdata, 0);
        r0_we = 0;
        #1;
        chk("rd_gnt0",   r0_gnt, 1);
        chk("rd_mem_we", mem_we, 0);
        @(negedge clk);
        chk("rd_ack0",   r0_ack, 1);
        chk("rd_rdata0", r0_rdata, 16'hBEEF);
        idle_all();
        @(negedge clk);
        chk("ack0_drop", r0_ack, 0);

        // Port 1 preloads @1 and @2
        r1_req = 1; r1_we = 1; r1_addr = 5'd1; r1_wdata = 16'h0011;
        #1 chk("pre_gnt1a", r1_gnt, 1);
        @(negedge clk);
        r1_addr = 5'd2; r1_wdata = 16'h0022;
        #1 chk("pre_gnt1b", r1_gnt, 1);
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Unlocked contention alternates, port 0 first after reset
        r0_req = 1; r0_addr = 5'd1;
        r1_req = 1; r1_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt_g1_%0d", i), r1_gnt, alt_exp[i]);
            chk($sformatf("alt_g0_%0d", i), r0_gnt, !alt_exp[i]);
            @(negedge clk);
        end
        chk("alt_rdata0", r0_rdata, 16'h0011);
        chk("alt_rdata1", r1_rdata, 16'h0022);
        idle_all();
        @(negedge clk);

        // Port 1 locked burst: alone for one cycle, then port 0 contends
        r1_req = 1; r1_lock = 1; r1_addr = 5'd2;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin r0_req = 1; r0_addr = 5'd1; end
            #1;
            chk($sformatf("burst_g1_%0d", i), r1_gnt, burst_exp[i]);
            chk($sformatf("burst_excl_%0d", i), r0_gnt & r1_gnt, 0);
            chk($sformatf("burst_any_%0d", i), r0_gnt | r1_gnt, 1);
            @(negedge clk);
        end
        idle_all();
        @(negedge clk);

        // Port 0 locked with no competitor keeps the memory
        r0_req = 1; r0_lock = 1; r0_addr = 5'd5;
        for (int i = 0; i < 10; i++) begin
            #1 chk($sformatf("solo_g0_%0d", i), r0_gnt, 1);
            @(negedge clk);
        end
        r1_req = 1; r1_addr = 5'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("relax_g1_%0d", i), r1_gnt, relax_exp[i]);
            chk($sformatf("relax_excl_%0d", i), r0_gnt & r1_gnt, 0);
            @(negedge clk);
        end
        chk("relax_rdata0", r0_rdata, 16'hBEEF);
        idle_all();
        @(negedge clk);

        // Read-after-write across ports
        r1_req = 1; r1_we = 1; r1_addr = 5'd3; r1_wdata = 16'h1234;
        #1 chk("raw_gnt1", r1_gnt, 1);
        @(negedge clk);
        idle_all();
        r0_req = 1; r0_addr = 5'd3;
        #1 chk("raw_gnt0", r0_gnt, 1);
        chk("raw_ack1", r1_ack, 1);
        chk("raw_rdata1_held", r1_rdata, 16'h0011);
        @(negedge clk);
        chk("raw_rdata0", r0_rdata, 16'h1234);
        idle_all();
        @(negedge clk);

        // Reset with a pending ack and port 1 owning the lock
        r1_req = 1; r1_lock = 1; r1_addr = 5'd3;
        @(negedge clk);
        chk("pre_rst_ack1", r1_ack, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack1", r1_ack, 0);
        chk("mid_rst_gnt1", r1_gnt, 0);
        chk("mid_rst_rdata1", r1_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        r0_req = 1; r0_addr = 5'd3;
        #1;
        chk("post_rst_g0", r0_gnt, 1);
        chk("post_rst_g1", r1_gnt, 0);
        @(negedge clk);
        chk("post_rst_rdata0", r0_rdata, 16'h1234);
        idle_all();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port 16-bit data memory between the CPU load/store unit (port 0) and a DMA/debug master (port 1).
- One access is granted per clock. Read data and acknowledgements are registered and returned one cycle later.
- Arbitration is round-robin, with an optional lock so a master can hold the memory for short bursts, bounded by a hold limit.
- Sits between the requesters and the data memory (asynchronous read, synchronous write).

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 16, data width.
- MAX_HOLD, 4, maximum consecutive grants to one locked owner while the other port is requesting (range 1..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- r0_req  input  1  port 0 access request
- r0_we  input  1  port 0 write (1) / read (0)
- r0_lock  input  1  port 0 requests to keep ownership
- r0_addr  input  ADDR_W  port 0 address
- r0_wdata  input  DATA_W  port 0 write data
- r0_gnt  output  1  port 0 access performed this cycle
- r0_ack  output  1  registered completion pulse
- r0_rdata  output  DATA_W  registered read data
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_ack, r1_rdata: same as port 0, for port 1
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_din  output  DATA_W  memory write data
- mem_dout  input  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- State register: owner ∈ {IDLE, OWN0, OWN1}; last (last served port, 1 bit); hold counter (4 bits).
- Reset (async): owner=IDLE, last=1 (port 0 wins the first tie), hold=0, r*_ack=0, r*_rdata=0. During reset, mem_we=0 and r*_gnt=0.
- Grant (combinational from state and current requests):
  - Only one port requesting: that port is granted.
  - Both requesting, owner=OWNk, rk_lock=1 and hold<MAX_HOLD: port k is granted.
  - Both requesting otherwise: the port != last is granted.
  - No request: no grant, mem_we=0; mem_addr/mem_din driven from port 0.
- r0_gnt and r1_gnt are never both 1.
- Memory drive in the granted cycle T:
  - mem_addr = rk_addr.
  - mem_din = rk_wdata.
  - mem_we = rk_we.
  - The write commits on the rising edge ending T.
- Response:
  - At the edge ending T, rk_ack<=1 for one cycle (read or write).
  - On a read, rk_rdata<=mem_dout. rk_rdata is otherwise held; it is not updated on writes.
  - Latency: request accepted in T, ack/data valid in T+1.
  - Throughput: 1 access/cycle when uncontested.
- Requester rule: keep req/we/addr/wdata stable until gnt is seen high in the same cycle. A request without gnt is not performed.
- State update at the edge after a granted cycle:
  - last<=k.
  - If rk_lock=1: owner<=OWNk.
  - If rk_lock=0: owner<=IDLE.
  - hold<=hold+1 if k equals the previous owner and the other port was requesting; otherwise hold<=1 (hold<=0 when owner goes IDLE).
  - hold saturates at MAX_HOLD.
- No grant in a cycle: owner<=IDLE, hold<=0, last unchanged.
- Lock dropped: the next contested cycle follows round-robin.
- Lock with no competitor: the counter does not advance, so the owner keeps the port indefinitely.
- Hold limit reached: the other port is granted. It becomes last, so the ex-owner regains the port only by round-robin.
- Read-after-write, same address, consecutive cycles: the read returns the new data (the write commits before the read cycle).
- Simultaneous write by one port and read by the other cannot occur (one grant per cycle).
- Reset mid-operation: pending acks are cleared and the arbiter returns to IDLE. A write whose edge coincides with rst assertion is not guaranteed, since mem_we is forced 0.

Test Plan:
- Reset then single write, then read:
  - r0 writes 0xBEEF@5 → r0_gnt=1 in the same cycle, r0_ack=1 next cycle.
  - r0 reads @5 → r0_rdata=0xBEEF one cycle after grant.
- Both ports request continuously without lock, reads of @1 (0x0011) and @2 (0x0022) → grants alternate 0,1,0,1… starting with port 0 after reset. r0_rdata=0x0011, r1_rdata=0x0022.
- Port 1 locked burst while port 0 requests, MAX_HOLD=4 → port 1 gets exactly 4 consecutive grants, then port 0 is granted. Check gnt never both 1.
- Port 0 locked, port 1 idle for 10 cycles → 10 consecutive r0 grants; then r1_req rises → r1 granted within MAX_HOLD cycles.
- Write 0x1234@3 by r1, then r0 reads @3 in the next cycle → r0_rdata=0x1234.
- Assert rst while r1_ack is pending and port 1 owns the lock → r1_ack=0 immediately, owner IDLE. After release, a contested request goes to port 0 first.
